// File: rtl/matrix_stream_pkg.sv
// Shared types and helpers for the matrix stream router and its UART serialiser.
package matrix_stream_pkg;

    // Order in which buffered elements are put on the line
    typedef enum logic {
        ROW_MAJOR = 1'b0,
        COL_MAJOR = 1'b1
    } traversal_e;

    // Top-level controller states
    typedef enum logic [1:0] {
        StLoad,
        StFull,
        StSend
    } state_e;

    // Sub-phases while sending: initial fetch, start request, frame in flight
    typedef enum logic [1:0] {
        PhFetch,
        PhIssue,
        PhFrame
    } phase_e;

    // Width able to hold every count from 0 up to num_elems inclusive
    function automatic int unsigned count_width(input int unsigned num_elems);
        return (num_elems < 1) ? 1 : $clog2(num_elems + 1);
    endfunction

endpackage

// File: rtl/matrix_uart_tx.sv
// UART frame serialiser: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Optional feature macro: MATRIX_STREAM_PARITY_EN inserts an even-parity bit before the stop bit.
module matrix_uart_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_serial,
    output logic              o_active,
    output logic              o_frame_done
);

`ifdef MATRIX_STREAM_PARITY_EN
    localparam int unsigned NumBits = DATA_W + 3;
`else
    localparam int unsigned NumBits = DATA_W + 2;
`endif
    localparam int unsigned BitW  = $clog2(NumBits);
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    localparam logic [BitW-1:0]  LastBit  = BitW'(NumBits - 1);
    localparam logic [BitW-1:0]  DataIdx  = BitW'(DATA_W);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    logic              active_q, active_d;
    logic              serial_q, serial_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
`ifdef MATRIX_STREAM_PARITY_EN
    logic              parity_q, parity_d;
`endif
    logic              baud_end;
    logic              last_bit;

    // Next-state: bit_q indexes the bit currently on the line (0 = start bit)
    always_comb begin
        active_d = active_q;
        serial_d = serial_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef MATRIX_STREAM_PARITY_EN
        parity_d = parity_q;
`endif
        baud_end     = (baud_q == BaudLast);
        last_bit     = (bit_q == LastBit);
        o_frame_done = active_q && baud_end && last_bit;

        if (!active_q) begin
            if (i_start) begin
                active_d = 1'b1;
                serial_d = 1'b0;
                shift_d  = i_data;
                baud_d   = '0;
                bit_d    = '0;
`ifdef MATRIX_STREAM_PARITY_EN
                parity_d = ^i_data;
`endif
            end
        end else if (baud_end) begin
            baud_d = '0;
            if (last_bit) begin
                active_d = 1'b0;
                serial_d = 1'b1;
            end else begin
                bit_d = bit_q + 1'b1;
                if (bit_q < DataIdx) begin
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
`ifdef MATRIX_STREAM_PARITY_EN
                end else if (bit_q == DataIdx) begin
                    serial_d = parity_q;
`endif
                end else begin
                    serial_d = 1'b1;
                end
            end
        end else begin
            baud_d = baud_q + 1'b1;
        end
    end

    // Frame state registers; reset drives the line idle-high at once
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_q <= 1'b0;
            serial_q <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
`ifdef MATRIX_STREAM_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            active_q <= active_d;
            serial_q <= serial_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
`ifdef MATRIX_STREAM_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign o_serial = serial_q;
    assign o_active = active_q;

endmodule

// File: rtl/matrix_stream_router.sv
// Buffers a ROWS x COLS byte matrix and streams it over UART in row- or column-major order.
// Optional feature macro: MATRIX_STREAM_PARITY_EN (forwarded to matrix_uart_tx).
module matrix_stream_router
    import matrix_stream_pkg::*;
#(
    parameter int unsigned ROWS         = 9,
    parameter int unsigned COLS         = 9,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst_n,
    input  logic                                    i_rx_valid,
    input  logic [DATA_W-1:0]                       i_rx_data,
    output logic                                    o_rx_ready,
    input  logic                                    i_trigger,
    input  logic                                    i_col_major,
    output logic                                    o_tx_serial,
    output logic                                    o_busy,
    output logic                                    o_done,
    output logic [count_width(ROWS*COLS)-1:0]       o_count
);

    localparam int unsigned NumElem = ROWS * COLS;
    localparam int unsigned CntW    = count_width(NumElem);
    localparam int unsigned RowW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned ColW    = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [CntW-1:0] LastIdx = CntW'(NumElem - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);
    localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);

    logic [DATA_W-1:0] mem_q [NumElem];

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    traversal_e        order_q, order_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [ColW-1:0]   col_q, col_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;

    logic              mem_we;
    logic [CntW-1:0]   addr;
    logic              at_last;
    logic              tx_start;
    logic              tx_active;
    logic              tx_frame_done;

    // Controller next-state; the next element is prefetched while the current frame is on the line
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        order_d  = order_q;
        count_d  = count_q;
        row_d    = row_q;
        col_d    = col_q;
        last_d   = last_q;
        rd_d     = rd_q;
        done_d   = 1'b0;
        mem_we   = 1'b0;
        addr     = CntW'(row_q * COLS + col_q);
        at_last  = (row_q == LastRow) && (col_q == LastCol);
        tx_start = (state_q == StSend) && (phase_q == PhIssue) && !tx_active;

        unique case (state_q)
            StLoad: begin
                if (i_rx_valid) begin
                    mem_we  = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == LastIdx) begin
                        state_d = StFull;
                    end
                end
            end
            StFull: begin
                if (i_trigger) begin
                    order_d = i_col_major ? COL_MAJOR : ROW_MAJOR;
                    state_d = StSend;
                    phase_d = PhFetch;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StSend: begin
                unique case (phase_q)
                    PhFetch: begin
                        rd_d    = mem_q[addr];
                        phase_d = PhIssue;
                    end
                    PhIssue: begin
                        last_d  = at_last;
                        phase_d = PhFrame;
                        if (!at_last) begin
                            if (order_q == ROW_MAJOR) begin
                                if (col_q == LastCol) begin
                                    col_d = '0;
                                    row_d = row_q + 1'b1;
                                end else begin
                                    col_d = col_q + 1'b1;
                                end
                            end else begin
                                if (row_q == LastRow) begin
                                    row_d = '0;
                                    col_d = col_q + 1'b1;
                                end else begin
                                    row_d = row_q + 1'b1;
                                end
                            end
                        end
                    end
                    PhFrame: begin
                        if (tx_frame_done) begin
                            if (last_q) begin
                                done_d  = 1'b1;
                                state_d = StLoad;
                                count_d = '0;
                                row_d   = '0;
                                col_d   = '0;
                            end else begin
                                rd_d    = mem_q[addr];
                                phase_d = PhIssue;
                            end
                        end
                    end
                    default: phase_d = PhFetch;
                endcase
            end
            default: state_d = StLoad;
        endcase

        busy_d  = (state_d == StSend);
        ready_d = (state_d == StLoad);
    end

    // Controller and registered-output state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StLoad;
            phase_q <= PhFetch;
            order_q <= ROW_MAJOR;
            count_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            rd_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            order_q <= order_d;
            count_q <= count_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Element storage; contents survive completion and are overwritten by the next load
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[count_q] <= i_rx_data;
        end
    end

    matrix_uart_tx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (tx_start),
        .i_data       (rd_q),
        .o_serial     (o_tx_serial),
        .o_active     (tx_active),
        .o_frame_done (tx_frame_done)
    );

    assign o_rx_ready = ready_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_count    = count_q;

endmodule

// File: tb/tb_matrix_stream_router.sv
// Directed bench for matrix_stream_router with a 2x3 byte matrix and 4 clocks per UART bit.
module tb_matrix_stream_router;

    localparam int unsigned ROWS = 2;
    localparam int unsigned COLS = 3;
    localparam int unsigned DW   = 8;
    localparam int unsigned CPB  = 4;
`ifdef MATRIX_STREAM_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif
    localparam int EP = 1 + NB * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_valid = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_ready;
    logic          trigger = 1'b0;
    logic          col_major = 1'b0;
    logic          tx_serial;
    logic          busy;
    logic          done;
    logic [2:0]    count;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    matrix_stream_router #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_rx_ready  (rx_ready),
        .i_trigger   (trigger),
        .i_col_major (col_major),
        .o_tx_serial (tx_serial),
        .o_busy      (busy),
        .o_done      (done),
        .o_count     (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bytes are taken from v starting at the least significant byte
    task automatic load_elems(input logic [47:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = v[8*i +: 8];
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_trigger(input logic cm, output int k);
        trigger   = 1'b1;
        col_major = cm;
        @(negedge clk);
        k         = cyc;
        trigger   = 1'b0;
        col_major = ~cm;
    endtask

    task automatic wait_fall(input string tag, output int s);
        bit seen = 1'b0;
        s = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) begin
                seen = 1'b1;
                s    = cyc;
                break;
            end
        end
        if (!seen) chk({tag, "_fall_timeout"}, 32'd0, 32'd1);
    endtask

    // Entered on the cycle the start bit begins; samples the middle of each bit
    task automatic rx_bits(input string tag, output logic [7:0] d);
        d = '0;
        repeat (2) @(negedge clk);
        chk({tag, "_start"}, {31'd0, tx_serial}, 32'd0);
        for (int j = 0; j < 8; j++) begin
            repeat (CPB) @(negedge clk);
            d[j] = tx_serial;
        end
`ifdef MATRIX_STREAM_PARITY_EN
        repeat (CPB) @(negedge clk);
        chk({tag, "_parity"}, {31'd0, tx_serial}, {31'd0, ^d});
`endif
        repeat (CPB) @(negedge clk);
        chk({tag, "_stop"}, {31'd0, tx_serial}, 32'd1);
    endtask

    task automatic send_check(input string tag, input logic cm, input logic [47:0] exp);
        int k;
        int s;
        int s_prev;
        int dc;
        logic [7:0] d;
        s_prev = 0;
        dc     = -1000;
        pulse_trigger(cm, k);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_ready_low"}, {31'd0, rx_ready}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            wait_fall(tag, s);
            if (i == 0) chk({tag, "_latency"}, s - k, 32'd2);
            else        chk({tag, "_period"}, s - s_prev, EP);
            s_prev = s;
            rx_bits(tag, d);
            chk({tag, "_data"}, {24'd0, d}, {24'd0, exp[8*i +: 8]});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        chk({tag, "_done_time"}, dc - k, 1 + 6 * EP);
        chk({tag, "_count_clr"}, {29'd0, count}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, rx_ready}, 32'd1);
        chk({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        int s;
        logic [7:0] d;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_serial", {31'd0, tx_serial}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_ready", {31'd0, rx_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Partial load, then a trigger that must be ignored
        load_elems(48'h00_00_00_13_12_11, 3);
        chk("partial_count", {29'd0, count}, 32'd3);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("early_trig_busy", {31'd0, busy}, 32'd0);
            chk("early_trig_line", {31'd0, tx_serial}, 32'd1);
        end
        load_elems(48'h00_00_00_16_15_14, 3);
        chk("full_count", {29'd0, count}, 32'd6);
        chk("full_ready", {31'd0, rx_ready}, 32'd0);

        // Extra element while full is dropped
        load_elems(48'h00_00_00_00_00_AA, 1);
        chk("drop_count", {29'd0, count}, 32'd6);
        chk("drop_ready", {31'd0, rx_ready}, 32'd0);

        send_check("row", 1'b0, 48'h16_15_14_13_12_11);

        load_elems(48'h16_15_14_13_12_11, 6);
        send_check("col", 1'b1, 48'h16_13_15_12_14_11);

        // Reset during a data bit of the second element
        load_elems(48'h16_15_14_13_12_11, 6);
        pulse_trigger(1'b0, k);
        wait_fall("mid", s);
        rx_bits("mid", d);
        chk("mid_first", {24'd0, d}, 32'h11);
        wait_fall("mid2", s);
        repeat (5) @(negedge clk);
        chk("mid_line_low", {31'd0, tx_serial}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_line", {31'd0, tx_serial}, 32'd1);
        chk("mid_rst_count", {29'd0, count}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_elems(48'h00_FF_80_01_C3_5A, 6);
        send_check("fresh", 1'b0, 48'h00_FF_80_01_C3_5A);

`ifdef MATRIX_STREAM_PARITY_EN
        load_elems(48'h03_07_03_07_03_07, 6);
        send_check("par", 1'b0, 48'h03_07_03_07_03_07);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
